// File: rtl/walk_request_bank.sv
// walk_request_bank: per-channel pedestrian button capture (sync + debounce + sticky flag)
// presented one at a time to the controller through a round-robin valid/ack handshake.
module walk_request_bank #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ID_W       = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] WR_Button,
  input  logic [NUM_CH-1:0] WR_Enable,
  input  logic [NUM_CH-1:0] WR_Clear,
  input  logic              WR_Ack,
  output logic              WR_Valid,
  output logic [ID_W-1:0]   WR_Id,
  output logic [NUM_CH-1:0] WR_Pending,
  output logic [ID_W:0]     WR_Count
);

  localparam int unsigned      CNT_OUT_W = ID_W + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_CH   = ID_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] sync_q1;
  logic [NUM_CH-1:0] sync_q2;
  logic [NUM_CH-1:0] deb_q;
  logic [NUM_CH-1:0] deb_dly_q;
  logic [CNT_W-1:0]  deb_cnt [NUM_CH];

  logic [NUM_CH-1:0] pend_q;
  logic [ID_W-1:0]   ptr_q;

  logic [NUM_CH-1:0] press_evt;
  logic              handshake;
  logic [NUM_CH-1:0] clr_mask;
  logic [NUM_CH-1:0] pend_next;
  logic [ID_W-1:0]   ptr_next;
  logic [ID_W-1:0]   sel_id;
  logic [CNT_OUT_W-1:0] ones;

  // Two-flop synchroniser followed by a per-channel stability counter.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        deb_cnt[ch] <= '0;
      end
    end else begin
      sync_q1   <= WR_Button;
      sync_q2   <= sync_q1;
      deb_dly_q <= deb_q;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (sync_q2[ch] == deb_q[ch]) begin
          deb_cnt[ch] <= '0;
        end else if (deb_cnt[ch] == DEB_LAST) begin
          deb_q[ch]   <= sync_q2[ch];
          deb_cnt[ch] <= '0;
        end else begin
          deb_cnt[ch] <= deb_cnt[ch] + CNT_W'(1);
        end
      end
    end
  end

  // A press is a debounced rising edge on an enabled channel; held buttons give one event.
  assign press_evt = deb_q & ~deb_dly_q & WR_Enable;
  assign WR_Valid  = |pend_q;
  assign handshake = WR_Valid & WR_Ack;

  // Round-robin pick: first pending channel scanning upward from the pointer, wrapping.
  always_comb begin
    int unsigned    scan;
    logic [ID_W-1:0] scan_id;
    logic           found;
    sel_id  = '0;
    scan    = 0;
    scan_id = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scan = 32'(ptr_q) + i;
      if (scan >= NUM_CH) begin
        scan = scan - NUM_CH;
      end
      scan_id = ID_W'(scan);
      if (!found && pend_q[scan_id]) begin
        sel_id = scan_id;
        found  = 1'b1;
      end
    end
  end

  // Next pending flags and pointer; a same-cycle press overrides any clear.
  always_comb begin
    clr_mask = WR_Clear;
    ptr_next = ptr_q;
    if (handshake) begin
      clr_mask[sel_id] = 1'b1;
      ptr_next = (sel_id == LAST_CH) ? '0 : sel_id + ID_W'(1);
    end
    pend_next = (pend_q & ~clr_mask) | press_evt;
  end

  // Pending flags and round-robin pointer registers.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pend_q <= '0;
      ptr_q  <= '0;
    end else begin
      pend_q <= pend_next;
      ptr_q  <= ptr_next;
    end
  end

  // Population count of the pending flags.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ones = ones + CNT_OUT_W'(pend_q[i]);
    end
  end

  assign WR_Id      = sel_id;
  assign WR_Pending = pend_q;
  assign WR_Count   = ones;

endmodule

// File: doc/walk_request_bank.md
Name: walk_request_bank

Overview:
Multi-channel successor to the single walk-request latch. It captures pedestrian push-button presses from N crosswalks, synchronises and debounces them, and holds a sticky pending flag per channel. It presents one pending request at a time to the traffic-light FSM through a valid/ack handshake with round-robin arbitration. It sits between the button pins and the main controller FSM.

Parameters:
NUM_CH, 4, number of crosswalk channels (1..16)
DEB_CYCLES, 16, number of consecutive stable synchronised samples needed to accept a level change (2..65535)
CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DEB_CYCLES
ID_W, 2, width of the channel index; equals clog2(NUM_CH), minimum 1

Ports:
clk  input  1  system clock; all state is updated on the rising edge
Reset  input  1  asynchronous, active-high reset
WR_Button  input  NUM_CH  raw, asynchronous push-button levels; 1 = pressed
WR_Enable  input  NUM_CH  per-channel enable; 0 blocks new presses on that channel
WR_Clear  input  NUM_CH  per-channel synchronous clear of the pending flag
WR_Ack  input  1  controller accepts the currently presented request
WR_Valid  output  1  at least one pending request is presented
WR_Id  output  ID_W  index of the presented channel
WR_Pending  output  NUM_CH  sticky pending flags, one per channel
WR_Count  output  ID_W+1  number of set bits in WR_Pending

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While Reset=1, all flops are 0: synchroniser stages, debounced levels, counters, pending flags and the round-robin pointer. Outputs are therefore WR_Valid=0, WR_Id=0, WR_Pending=0, WR_Count=0. Asserting Reset in the middle of a debounce or a handshake discards all state.
- Synchroniser: each WR_Button bit passes through two flops.
- Debounce, per channel:
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYCLES-1, the debounced level takes the synchronised level and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the debounced level.
- Press event: a one-cycle rise of the debounced level (0->1) while WR_Enable=1 for that channel. Holding the button down gives exactly one event. A press while WR_Enable=0 is dropped, not deferred.
- Pending flag:
  - Set by a press event.
  - Cleared by WR_Clear, or by an accepted handshake on that channel.
  - If a set and a clear hit the same channel in the same cycle, set wins.
  - A press on a channel that is already pending has no effect; requests are not counted.
- Arbitration:
  - WR_Valid = |WR_Pending (combinational from the registered flags).
  - WR_Id is the first pending channel found scanning upward from the pointer, wrapping from NUM_CH-1 to 0.
  - When WR_Valid=0, WR_Id is 0.
- Handshake:
  - A handshake completes in any cycle where WR_Valid=1 and WR_Ack=1.
  - On completion, the presented channel's flag clears and the pointer moves to WR_Id+1 (mod NUM_CH) at the next edge.
  - WR_Id changes only after a completed handshake, a WR_Clear on the presented channel, or a new press on a channel earlier in the scan order.
  - WR_Ack while WR_Valid=0 is ignored.
- Latency: a clean press sets WR_Pending 2 (sync) + DEB_CYCLES + 1 cycles after the pin rises. WR_Valid follows in the same cycle.
- WR_Count is combinational from WR_Pending and is always in the range 0..NUM_CH.

Test Plan:
- Reset: assert Reset mid-run with two flags pending -> immediately WR_Pending=0, WR_Valid=0, WR_Count=0; after release, the next press is accepted normally.
- Debounce (NUM_CH=4, DEB_CYCLES=16): a 10-cycle pulse on WR_Button[1] -> no flag set. A 40-cycle press -> WR_Pending=4'b0010 exactly 19 cycles after the pin rises, and a single event only.
- Round-robin: press channels 0, 2 and 3 with the pointer at 0, then ack each cycle -> WR_Id sequence 0, 2, 3, then WR_Valid=0. WR_Count steps 3, 2, 1, 0.
- Simultaneous set and clear: a press event on channel 2 in the same cycle as WR_Clear[2]=1 -> WR_Pending[2]=1 after the edge. A press event on the presented channel in the ack cycle -> flag stays 1.
- Enable gating: with WR_Enable[3]=0, a 40-cycle press on channel 3 -> WR_Pending[3] stays 0. Setting WR_Enable[3]=1 while the button is still held -> no event; a new release and press -> flag set.
- Ack while idle: WR_Ack=1 with no flags pending -> no state change and the pointer holds. A subsequent press on channel 1 -> WR_Id=1.
